// File: rtl/fetch_s_if.sv
// Fetch-unit bus: ROM read port, execute redirect and the decode valid/ready handshake.
// FETCH_MISALIGN_EN adds the sticky misalign_err flag.
interface fetch_s_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic              id_ready;
`ifdef FETCH_MISALIGN_EN
    logic              misalign_err;

    modport master (
        output rom_addr,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_pc,
        output if_instr,
        input  id_ready,
        output misalign_err
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output id_ready,
        input  misalign_err
    );
`else
    modport master (
        output rom_addr,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_pc,
        output if_instr,
        input  id_ready
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output id_ready
    );
`endif
endinterface

// File: rtl/fetch_s.sv
// Instruction fetch unit: drives a 1-cycle-latency ROM from pc_req, buffers {pc, instr} in a 2-entry FIFO.
// Optional FETCH_MISALIGN_EN: misaligned redirect raises sticky misalign_err and halts issue.
module fetch_s #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic      clk,
    input  logic      rst,
    fetch_s_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]       pc_req;
    logic              resp_valid;
    logic [31:0]       resp_pc;
    logic [ADDR_W-1:0] last_addr;

    logic [1:0]        count;
    logic              head_vld;
    logic [31:0]       head_pc;
    logic [31:0]       head_instr;
    logic [31:0]       tail_pc;
    logic [31:0]       tail_instr;

    logic [1:0]        n_count;
    logic [31:0]       n_head_pc;
    logic [31:0]       n_head_instr;
    logic [31:0]       n_tail_pc;
    logic [31:0]       n_tail_instr;
    logic [1:0]        cnt;
    logic              pop;
    logic              issue;
    logic              halted;
    logic              misaligned;
    logic [31:0]       tgt_pc;

    assign tgt_pc = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
    logic misalign_err;
    assign misaligned       = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign bus.misalign_err = misalign_err;
`else
    logic unused_lsb;
    assign unused_lsb = ^bus.redirect_pc[1:0];
    assign misaligned = 1'b0;
    assign halted     = 1'b0;
`endif

    // Queue bookkeeping: a redirect flushes everything and drops the in-flight response.
    always_comb begin
        pop          = head_vld && bus.id_ready && !bus.redirect_valid;
        n_count      = count;
        n_head_pc    = head_pc;
        n_head_instr = head_instr;
        n_tail_pc    = tail_pc;
        n_tail_instr = tail_instr;
        cnt          = count;
        if (bus.redirect_valid) begin
            n_count = 2'd0;
        end else begin
            if (pop) begin
                n_head_pc    = tail_pc;
                n_head_instr = tail_instr;
                cnt          = count - 2'd1;
            end
            if (resp_valid) begin
                if (cnt == 2'd0) begin
                    n_head_pc    = resp_pc;
                    n_head_instr = bus.rom_instr;
                end else begin
                    n_tail_pc    = resp_pc;
                    n_tail_instr = bus.rom_instr;
                end
                cnt = cnt + 2'd1;
            end
            n_count = cnt;
        end
    end

    // Issue only while the queue can still absorb the response that lands next cycle.
    always_comb begin
        issue = !bus.redirect_valid && !halted && (n_count <= 2'd1);
        if (rst) begin
            bus.rom_addr = RESET_PC[ADDR_W+1:2];
        end else if (bus.redirect_valid) begin
            bus.rom_addr = bus.redirect_pc[ADDR_W+1:2];
        end else if (issue) begin
            bus.rom_addr = pc_req[ADDR_W+1:2];
        end else begin
            bus.rom_addr = last_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_req     <= RESET_PC;
            resp_valid <= 1'b0;
            last_addr  <= RESET_PC[ADDR_W+1:2];
            count      <= 2'd0;
            head_vld   <= 1'b0;
        end else begin
            count    <= n_count;
            head_vld <= (n_count != 2'd0);
            if (bus.redirect_valid && !halted) begin
                if (misaligned) begin
                    resp_valid <= 1'b0;
                end else begin
                    resp_valid <= 1'b1;
                    pc_req     <= tgt_pc + 32'd4;
                    last_addr  <= bus.redirect_pc[ADDR_W+1:2];
                end
            end else if (issue) begin
                resp_valid <= 1'b1;
                pc_req     <= pc_req + 32'd4;
                last_addr  <= pc_req[ADDR_W+1:2];
            end else begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            halted       <= 1'b1;
            misalign_err <= 1'b1;
        end
    end
`endif

    // Head entry is visible on the outputs, so it carries a defined reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc    <= 32'd0;
            head_instr <= NOP;
        end else begin
            head_pc    <= n_head_pc;
            head_instr <= n_head_instr;
        end
    end

    always_ff @(posedge clk) begin
        tail_pc    <= n_tail_pc;
        tail_instr <= n_tail_instr;
        if (bus.redirect_valid) begin
            resp_pc <= tgt_pc;
        end else if (issue) begin
            resp_pc <= pc_req;
        end
    end

    assign bus.if_valid = head_vld;
    assign bus.if_pc    = head_pc;
    assign bus.if_instr = head_instr;
endmodule
